// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared definitions for the down_timer block.
// Holds the FSM state encoding and the default widths used by the
// interface, the top and the optional prescaler.
// Optional feature macro: DOWN_TIMER_PRESCALE_EN (adds the step prescaler).
package down_timer_pkg;

    // Default count width, matches the cnt width of the up-counter.
    localparam int DEF_WIDTH      = 4;
    // Default prescaler compare width.
    localparam int DEF_PRESCALE_W = 8;

    // Timer FSM state encoding.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Expiry condition: a step taken while the count sits at one.
    function automatic logic is_expiry(input logic run, input logic step,
                                       input logic [DEF_WIDTH-1:0] cnt_lo,
                                       input logic upper_zero);
        return run && step && upper_zero && (cnt_lo == DEF_WIDTH'(1));
    endfunction

endpackage

// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle of the down_timer.
// Handshake: there is no valid/ready pair; load and irq_ack are single-cycle
// strobes sampled on the rising clock edge, en/auto_reload are levels, and all
// status outputs (cnt, busy, done, irq, dbg_state) are registered.
// The prescale field exists only when DOWN_TIMER_PRESCALE_EN is defined.
interface down_timer_if
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef DOWN_TIMER_PRESCALE_EN
    ,
    parameter int PRESCALE_W = DEF_PRESCALE_W
`endif
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic             irq_ack;
`ifdef DOWN_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
`endif
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic             irq;
    state_e           dbg_state;

    // Controller side: drives the strobes, observes the status.
    modport master (
`ifdef DOWN_TIMER_PRESCALE_EN
        output prescale,
`endif
        output en, load, load_val, auto_reload, irq_ack,
        input  cnt, busy, done, irq, dbg_state
    );

    // Timer side.
    modport slave (
`ifdef DOWN_TIMER_PRESCALE_EN
        input  prescale,
`endif
        input  en, load, load_val, auto_reload, irq_ack,
        output cnt, busy, done, irq, dbg_state
    );

endinterface

// File: rtl/down_timer_prescaler.sv
// timer_prescaler: divides enabled cycles into step ticks.
// tick is high once every prescale+1 enabled cycles; prescale = 0 gives a
// tick on every enabled cycle. Only instantiated with DOWN_TIMER_PRESCALE_EN.
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  restart,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] pcnt;

    // >= rather than == so a prescale lowered mid-count still ticks promptly.
    assign tick = en && (pcnt >= prescale);

    // Divider count: cleared on reset/restart, advances only on enabled cycles.
    always_ff @(posedge clk) begin
        if (clr || restart) begin
            pcnt <= '0;
        end else if (en) begin
            if (tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/down_timer.sv
// down_timer: programmable down-counting timer with one-cycle done pulse,
// sticky irq flag and one-shot / auto-reload modes.
// Optional feature macro: DOWN_TIMER_PRESCALE_EN (step prescaler + prescale
// field on the interface). Without it every enabled cycle is a step.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef DOWN_TIMER_PRESCALE_EN
    ,
    parameter int PRESCALE_W = DEF_PRESCALE_W
`endif
) (
    input  logic         clk,
    input  logic         clr,
    down_timer_if.slave  bus
);
    state_e           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] reload;
    logic             busy;
    logic             done;
    logic             irq;

    logic             tick;
    logic             step;
    logic             expiry;

    assign step   = bus.en && tick;
    // Expiry is the last step of a run; load takes priority over it below.
    assign expiry = (state == RUN) && step && (cnt == WIDTH'(1));

`ifdef DOWN_TIMER_PRESCALE_EN
    logic pre_restart;
    logic pre_en;

    // The prescaler restarts its phase on every load and every expiry.
    assign pre_restart = bus.load || expiry;
    assign pre_en      = bus.en && (state == RUN);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .clr      (clr),
        .restart  (pre_restart),
        .en       (pre_en),
        .prescale (bus.prescale),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Timer FSM: load/restart, decrement, expiry handling and irq flag.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            reload <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            done <= 1'b0;
            // Ack first so a coincident expiry below re-sets irq (set wins).
            if (bus.irq_ack) begin
                irq <= 1'b0;
            end
            if (bus.load) begin
                // A zero load parks the timer: no run, no done, no irq.
                cnt    <= bus.load_val;
                reload <= bus.load_val;
                if (bus.load_val != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (expiry) begin
                done <= 1'b1;
                irq  <= 1'b1;
                if (bus.auto_reload) begin
                    cnt <= reload;
                end else begin
                    cnt   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if ((state == RUN) && step && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.cnt       = cnt;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.irq       = irq;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed, self-checking bench for down_timer.
// Inputs change #1 after a rising edge; outputs are sampled at that point,
// so each check sees the state produced by the edge just passed.
module tb_down_timer;
    import down_timer_pkg::*;

    localparam int W = 4;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;

`ifdef DOWN_TIMER_PRESCALE_EN
    down_timer_if #(.WIDTH(W), .PRESCALE_W(8)) bus ();
    down_timer #(.WIDTH(W), .PRESCALE_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );
`else
    down_timer_if #(.WIDTH(W)) bus ();
    down_timer #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );
`endif

    // Clock/reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Compact status check: cnt, done, irq, busy.
    task automatic check_st(input string tag, input int c, input bit d, input bit q, input bit b);
        check({tag, ".cnt"},  32'(bus.cnt),  32'(c));
        check({tag, ".done"}, 32'(bus.done), 32'(d));
        check({tag, ".irq"},  32'(bus.irq),  32'(q));
        check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    endtask

    task automatic do_load(input int v);
        bus.load     = 1'b1;
        bus.load_val = W'(v);
        tick_clk(1);
        bus.load     = 1'b0;
    endtask

    task automatic ack_only();
        bus.irq_ack = 1'b1;
        tick_clk(1);
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clr             = 1'b1;
        bus.en          = 1'b0;
        bus.load        = 1'b1;
        bus.load_val    = W'(5);
        bus.auto_reload = 1'b0;
        bus.irq_ack     = 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
        bus.prescale    = '0;
`endif
        // Reset wins over a coincident load.
        tick_clk(2);
        clr      = 1'b0;
        bus.load = 1'b0;
        check_st("rst", 0, 0, 0, 0);
        check("rst.state", 32'(bus.dbg_state), 32'(IDLE));
        tick_clk(1);
        check_st("rst_hold", 0, 0, 0, 0);

        // One-shot of 3.
        bus.en = 1'b1;
        do_load(3);
        check_st("os0", 3, 0, 0, 1);
        tick_clk(1); check_st("os1", 2, 0, 0, 1);
        tick_clk(1); check_st("os2", 1, 0, 0, 1);
        tick_clk(1); check_st("os3", 0, 1, 1, 0);
        check("os3.state", 32'(bus.dbg_state), 32'(IDLE));
        tick_clk(1); check_st("os4", 0, 0, 1, 0);
        ack_only();  check_st("os_ack", 0, 0, 0, 0);

        // Auto-reload of 2 with acks.
        bus.auto_reload = 1'b1;
        do_load(2);
        check_st("ar0", 2, 0, 0, 1);
        tick_clk(1); check_st("ar1", 1, 0, 0, 1);
        tick_clk(1); check_st("ar2", 2, 1, 1, 1);
        tick_clk(1); check_st("ar3", 1, 0, 1, 1);
        bus.irq_ack = 1'b1;
        tick_clk(1);
        bus.irq_ack = 1'b0;
        check_st("ar4_set_wins", 2, 1, 1, 1);
        bus.irq_ack = 1'b1;
        tick_clk(1);
        bus.irq_ack = 1'b0;
        check_st("ar5_ack", 1, 0, 0, 1);

        // Pause: load 4 while running, drop en at cnt = 2.
        bus.auto_reload = 1'b0;
        do_load(4);
        check_st("pz0", 4, 0, 0, 1);
        tick_clk(2); check_st("pz2", 2, 0, 0, 1);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_clk(1);
            check_st("pz_hold", 2, 0, 0, 1);
        end
        bus.en = 1'b1;
        tick_clk(1); check_st("pz3", 1, 0, 0, 1);
        tick_clk(1); check_st("pz4", 0, 1, 1, 0);
        ack_only();

        // Load 7 coincident with an expiry step: load wins, no done.
        do_load(3);
        tick_clk(2); check_st("lp1", 1, 0, 0, 1);
        do_load(7);
        check_st("lp_prio", 7, 0, 0, 1);
        tick_clk(1); check_st("lp_dec", 6, 0, 0, 1);

        // Load 0: parks in IDLE with no done/irq.
        do_load(0);
        check_st("z0", 0, 0, 0, 0);
        check("z0.state", 32'(bus.dbg_state), 32'(IDLE));
        tick_clk(1); check_st("z1", 0, 0, 0, 0);

        // Load 9 then reset at cnt = 5.
        do_load(9);
        check_st("cr0", 9, 0, 0, 1);
        tick_clk(4); check_st("cr4", 5, 0, 0, 1);
        clr = 1'b1;
        tick_clk(1);
        clr = 1'b0;
        check_st("cr_clr", 0, 0, 0, 0);
        tick_clk(1); check_st("cr_after", 0, 0, 0, 0);

        // Auto-reload of 1: done on every step.
        bus.auto_reload = 1'b1;
        do_load(1);
        check_st("one0", 1, 0, 0, 1);
        tick_clk(1); check_st("one1", 1, 1, 1, 1);
        tick_clk(1); check_st("one2", 1, 1, 1, 1);
        // Max value wraps nothing: 15 reloads to 15.
        do_load(15);
        check_st("max0", 15, 0, 1, 1);
        tick_clk(14); check_st("max14", 1, 0, 1, 1);
        tick_clk(1);  check_st("max15", 15, 1, 1, 1);
        clr = 1'b1;
        tick_clk(1);
        clr = 1'b0;
        bus.auto_reload = 1'b0;

`ifdef DOWN_TIMER_PRESCALE_EN
        // prescale = 2: a step every 3 enabled cycles, done 6 cycles after load.
        bus.prescale = 8'd2;
        do_load(2);
        check_st("ps0", 2, 0, 0, 1);
        tick_clk(1); check_st("ps1", 2, 0, 0, 1);
        tick_clk(1); check_st("ps2", 2, 0, 0, 1);
        tick_clk(1); check_st("ps3", 1, 0, 0, 1);
        tick_clk(1); check_st("ps4", 1, 0, 0, 1);
        tick_clk(1); check_st("ps5", 1, 0, 0, 1);
        tick_clk(1); check_st("ps6", 0, 1, 1, 0);
        tick_clk(1); check_st("ps7", 0, 0, 1, 0);
        bus.prescale = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
